lock_controller: RTL and testbench

Canal-lock sequencer that sits directly upstream of the two gondola gate instances. It latches gondola arrival requests from the low (left) and high (right) sides and tracks the chamber water level with a fill/drain counter. It drives each gate's open request only when the chamber level matches that side. Its `openLeft`/`openRight` outputs connect to the `openCase` inputs of the left and right gate blocks.

---
 rtl/lock_controller_if.sv | 27 ++
 rtl/lock_controller.sv | 154 +++++++++++++++
 tb/tb_lock_controller.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_controller_if.sv
// Signal bundle between the canal-lock sequencer and the gondola/gate environment.
// The controller takes the slave side; the environment or bench takes the master side.
interface lock_controller_if #(
  parameter int LEVEL_W = 4
);
  logic               arriveLeft;
  logic               arriveRight;
  logic               inChamber;
  logic               crossed;
  logic               openLeft;
  logic               openRight;
  logic [LEVEL_W-1:0] level;
  logic               filling;
  logic               draining;
  logic               waitL;
  logic               waitR;

  modport master (
    output arriveLeft, arriveRight, inChamber, crossed,
    input  openLeft, openRight, level, filling, draining, waitL, waitR
  );

  modport slave (
    input  arriveLeft, arriveRight, inChamber, crossed,
    output openLeft, openRight, level, filling, draining, waitL, waitR
  );
endinterface

// File: rtl/lock_controller.sv
// Canal-lock sequencer: latches gondola requests at both sides, runs the chamber
// fill/drain counter and requests a gate opening only when the water level matches.
module lock_controller #(
  parameter int LEVEL_MAX = 8,
  parameter int LEVEL_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  lock_controller_if.slave bus
);

  localparam logic [2:0] ST_LOW    = 3'd0;
  localparam logic [2:0] ST_OPEN_L = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_HIGH   = 3'd3;
  localparam logic [2:0] ST_OPEN_R = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;

  localparam logic [LEVEL_W-1:0] LVL_ZERO = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LVL_ONE  = {{(LEVEL_W-1){1'b0}}, 1'b1};
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_TOP  = LVL_MAX - LVL_ONE;

  logic [2:0]         state_r;
  logic [2:0]         state_s;
  logic [LEVEL_W-1:0] level_r;
  logic [LEVEL_W-1:0] level_s;
  logic               wait_l_r;
  logic               wait_l_s;
  logic               wait_r_r;
  logic               wait_r_s;
  logic               enter_open_l_s;
  logic               enter_open_r_s;
  logic               open_left_r;
  logic               open_right_r;
  logic               filling_r;
  logic               draining_r;

  // Next state and chamber level; the level only moves in FILL/DRAIN and clamps at the marks
  always_comb begin
    state_s = state_r;
    level_s = level_r;
    case (state_r)
      ST_LOW: begin
        if (bus.inChamber || wait_l_r) begin
          state_s = ST_OPEN_L;
        end else if (wait_r_r) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_LOW;
        end
      end
      ST_OPEN_L: begin
        if (bus.crossed) begin
          state_s = bus.inChamber ? ST_FILL : ST_LOW;
        end else begin
          state_s = ST_OPEN_L;
        end
      end
      ST_FILL: begin
        if (level_r < LVL_MAX) begin
          level_s = level_r + LVL_ONE;
        end else begin
          level_s = LVL_MAX;
        end
        if (level_r >= LVL_TOP) begin
          state_s = ST_HIGH;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_HIGH: begin
        if (bus.inChamber || wait_r_r) begin
          state_s = ST_OPEN_R;
        end else if (wait_l_r) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_OPEN_R: begin
        if (bus.crossed) begin
          state_s = bus.inChamber ? ST_DRAIN : ST_HIGH;
        end else begin
          state_s = ST_OPEN_R;
        end
      end
      ST_DRAIN: begin
        if (level_r > LVL_ZERO) begin
          level_s = level_r - LVL_ONE;
        end else begin
          level_s = LVL_ZERO;
        end
        if (level_r <= LVL_ONE) begin
          state_s = ST_LOW;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_LOW;
        level_s = LVL_ZERO;
      end
    endcase
  end

  // Sticky requests; the clear on the OPEN entry edge wins over a same-edge arrival
  always_comb begin
    enter_open_l_s = (state_s == ST_OPEN_L) && (state_r != ST_OPEN_L);
    enter_open_r_s = (state_s == ST_OPEN_R) && (state_r != ST_OPEN_R);
    if (enter_open_l_s) begin
      wait_l_s = 1'b0;
    end else begin
      wait_l_s = wait_l_r | bus.arriveLeft;
    end
    if (enter_open_r_s) begin
      wait_r_s = 1'b0;
    end else begin
      wait_r_s = wait_r_r | bus.arriveRight;
    end
  end

  // State, level, requests and registered Moore outputs decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_LOW;
      level_r      <= LVL_ZERO;
      wait_l_r     <= 1'b0;
      wait_r_r     <= 1'b0;
      open_left_r  <= 1'b0;
      open_right_r <= 1'b0;
      filling_r    <= 1'b0;
      draining_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      level_r      <= level_s;
      wait_l_r     <= wait_l_s;
      wait_r_r     <= wait_r_s;
      open_left_r  <= (state_s == ST_OPEN_L);
      open_right_r <= (state_s == ST_OPEN_R);
      filling_r    <= (state_s == ST_FILL);
      draining_r   <= (state_s == ST_DRAIN);
    end
  end

  assign bus.openLeft  = open_left_r;
  assign bus.openRight = open_right_r;
  assign bus.level     = level_r;
  assign bus.filling   = filling_r;
  assign bus.draining  = draining_r;
  assign bus.waitL     = wait_l_r;
  assign bus.waitR     = wait_r_r;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with LEVEL_MAX=8: inputs change 1 time unit
// after a rising edge and outputs are checked at that same point.
module tb_lock_controller;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  lock_controller_if #(.LEVEL_W(4)) bus ();

  lock_controller #(.LEVEL_MAX(8), .LEVEL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("gates_exclusive", 32'(bus.openLeft & bus.openRight), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    bus.arriveLeft  = 1'b0;
    bus.arriveRight = 1'b0;
    bus.inChamber   = 1'b0;
    bus.crossed     = 1'b0;
    #3;
    chk("rst_openLeft",  32'(bus.openLeft),  32'd0);
    chk("rst_openRight", 32'(bus.openRight), 32'd0);
    chk("rst_level",     32'(bus.level),     32'd0);
    chk("rst_filling",   32'(bus.filling),   32'd0);
    chk("rst_draining",  32'(bus.draining),  32'd0);
    chk("rst_waitL",     32'(bus.waitL),     32'd0);
    chk("rst_waitR",     32'(bus.waitR),     32'd0);
    #9 reset = 1'b1;

    // Left entry, right exit
    bus.arriveLeft = 1'b1;
    tick();
    bus.arriveLeft = 1'b0;
    chk("le_waitL_latched", 32'(bus.waitL), 32'd1);
    chk("le_openLeft_early", 32'(bus.openLeft), 32'd0);
    tick();
    chk("le_openLeft", 32'(bus.openLeft), 32'd1);
    chk("le_waitL_cleared", 32'(bus.waitL), 32'd0);
    bus.inChamber = 1'b1;
    bus.crossed   = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("le_openLeft_off", 32'(bus.openLeft), 32'd0);
    chk("le_fill_entry", 32'(bus.filling), 32'd1);
    chk("le_fill_level0", 32'(bus.level), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("le_fill_level", 32'(bus.level), i);
      chk("le_filling", 32'(bus.filling), (i < 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk("le_openRight", 32'(bus.openRight), 32'd1);
    bus.inChamber = 1'b0;
    bus.crossed   = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("le_openRight_off", 32'(bus.openRight), 32'd0);
    chk("le_high_level", 32'(bus.level), 32'd8);

    // Ignored crossed in HIGH
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("ign_high_openRight", 32'(bus.openRight), 32'd0);
    chk("ign_high_draining", 32'(bus.draining), 32'd0);
    chk("ign_high_level", 32'(bus.level), 32'd8);

    // Drain back down for a low-side request
    bus.arriveLeft = 1'b1;
    tick();
    bus.arriveLeft = 1'b0;
    chk("dr_waitL", 32'(bus.waitL), 32'd1);
    chk("dr_not_yet", 32'(bus.draining), 32'd0);
    tick();
    chk("dr_entry", 32'(bus.draining), 32'd1);
    chk("dr_entry_level", 32'(bus.level), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("dr_level", 32'(bus.level), 8 - i);
      chk("dr_draining", 32'(bus.draining), (i < 8) ? 32'd1 : 32'd0);
    end
    tick();
    chk("dr_openLeft", 32'(bus.openLeft), 32'd1);
    chk("dr_waitL_cleared", 32'(bus.waitL), 32'd0);
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("dr_low_openLeft", 32'(bus.openLeft), 32'd0);
    chk("dr_low_filling", 32'(bus.filling), 32'd0);

    // Ignored crossed in LOW
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("ign_low_openLeft", 32'(bus.openLeft), 32'd0);
    chk("ign_low_filling", 32'(bus.filling), 32'd0);
    chk("ign_low_level", 32'(bus.level), 32'd0);

    // Arrival held across the OPEN_L entry edge is absorbed
    bus.arriveLeft = 1'b1;
    tick();
    chk("abs_latched", 32'(bus.waitL), 32'd1);
    tick();
    bus.arriveLeft = 1'b0;
    chk("abs_openLeft", 32'(bus.openLeft), 32'd1);
    chk("abs_waitL_clear", 32'(bus.waitL), 32'd0);
    tick();
    chk("abs_waitL_stays", 32'(bus.waitL), 32'd0);
    bus.arriveLeft = 1'b1;
    tick();
    bus.arriveLeft = 1'b0;
    chk("abs_relatch", 32'(bus.waitL), 32'd1);
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("abs_low_openLeft", 32'(bus.openLeft), 32'd0);
    tick();
    chk("abs_reserve", 32'(bus.openLeft), 32'd1);
    chk("abs_reserve_wait", 32'(bus.waitL), 32'd0);
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("abs_back_low", 32'(bus.openLeft), 32'd0);

    // Simultaneous arrivals in LOW: left first, then fill and serve right
    bus.arriveLeft  = 1'b1;
    bus.arriveRight = 1'b1;
    tick();
    bus.arriveLeft  = 1'b0;
    bus.arriveRight = 1'b0;
    chk("sim_waitL", 32'(bus.waitL), 32'd1);
    chk("sim_waitR", 32'(bus.waitR), 32'd1);
    tick();
    chk("sim_openLeft", 32'(bus.openLeft), 32'd1);
    chk("sim_waitR_kept", 32'(bus.waitR), 32'd1);
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("sim_low", 32'(bus.openLeft), 32'd0);
    chk("sim_low_filling", 32'(bus.filling), 32'd0);
    tick();
    chk("sim_fill", 32'(bus.filling), 32'd1);
    repeat (8) tick();
    chk("sim_high_level", 32'(bus.level), 32'd8);
    tick();
    chk("sim_openRight", 32'(bus.openRight), 32'd1);
    chk("sim_waitR_clear", 32'(bus.waitR), 32'd0);
    // Back-to-back crossed: second pulse lands in HIGH and is ignored
    bus.crossed = 1'b1;
    tick();
    chk("b2b_first", 32'(bus.openRight), 32'd0);
    tick();
    bus.crossed = 1'b0;
    chk("b2b_second_open", 32'(bus.openRight), 32'd0);
    chk("b2b_second_drain", 32'(bus.draining), 32'd0);
    chk("b2b_level", 32'(bus.level), 32'd8);

    // Return to LOW via a left request, then serve it
    bus.arriveLeft = 1'b1;
    tick();
    bus.arriveLeft = 1'b0;
    repeat (9) tick();
    chk("ret_level", 32'(bus.level), 32'd0);
    tick();
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("ret_low", 32'(bus.openLeft), 32'd0);

    // Right request from empty: openRight exactly 10 edges after the latching edge
    bus.arriveRight = 1'b1;
    tick();
    bus.arriveRight = 1'b0;
    chk("rr_waitR", 32'(bus.waitR), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      bus.crossed = (k == 4) ? 1'b1 : 1'b0;
      tick();
      bus.crossed = 1'b0;
      if (k < 10) begin
        chk("rr_openRight_early", 32'(bus.openRight), 32'd0);
        chk("rr_level", 32'(bus.level), k - 1);
      end else begin
        chk("rr_openRight", 32'(bus.openRight), 32'd1);
        chk("rr_waitR_clear", 32'(bus.waitR), 32'd0);
        chk("rr_level_top", 32'(bus.level), 32'd8);
      end
    end
    bus.crossed = 1'b1;
    tick();
    bus.crossed = 1'b0;
    chk("rr_exit", 32'(bus.openRight), 32'd0);

    // Asynchronous reset from HIGH
    #2 reset = 1'b0;
    #1;
    chk("arst_high_level", 32'(bus.level), 32'd0);
    #2 reset = 1'b1;

    // Asynchronous reset mid-FILL at level 5
    bus.arriveRight = 1'b1;
    tick();
    bus.arriveRight = 1'b0;
    tick();
    repeat (5) tick();
    chk("mf_level5", 32'(bus.level), 32'd5);
    chk("mf_filling", 32'(bus.filling), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mf_rst_level", 32'(bus.level), 32'd0);
    chk("mf_rst_filling", 32'(bus.filling), 32'd0);
    chk("mf_rst_openLeft", 32'(bus.openLeft), 32'd0);
    chk("mf_rst_openRight", 32'(bus.openRight), 32'd0);
    chk("mf_rst_waitR", 32'(bus.waitR), 32'd0);
    #2 reset = 1'b1;
    tick();
    chk("mf_post_filling", 32'(bus.filling), 32'd0);
    chk("mf_post_level", 32'(bus.level), 32'd0);
    chk("mf_post_openLeft", 32'(bus.openLeft), 32'd0);
    chk("mf_post_openRight", 32'(bus.openRight), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
